// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared width, iteration count, ALU divide codes and FSM states
package seq_divider_pkg;
  localparam int WIDTH = 32;
  localparam int ITER_COUNT = WIDTH;
  localparam logic [3:0] ALU_DIV = 4'b1100;
  localparam logic [3:0] ALU_DIVU = 4'b1101;
  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one combinational restoring shift-subtract iteration
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] div_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);
  logic [W:0] sh;
  logic [W:0] diff;
  logic       ge;
  always_comb begin
    sh = {rem_i, quo_i[W-1]};
    diff = sh - {1'b0, div_i};
    ge = ~diff[W];
    rem_o = ge ? diff[W-1:0] : sh[W-1:0];
    quo_o = {quo_i[W-2:0], ge};
  end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed/unsigned restoring divider with registered results and flags
module seq_divider #(
  parameter int WIDTH = seq_divider_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             zero_flag,
  output logic             sign_flag,
  output logic             overflow_flag,
  output logic             div_by_zero
);
  import seq_divider_pkg::*;
  state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [3:0] op_q, op_d;
  logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] pr_q, pr_d, pq_q, pq_d, md_q, md_d;
  logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic zero_q, zero_d, sign_q, sign_d, ovf_q, ovf_d, dbz_q, dbz_d;
  logic [WIDTH-1:0] pr_n, pq_n, q_fix, r_fix;
  logic sg, dvd_neg, dvs_neg;
  div_step #(.W(WIDTH)) u_step (
    .rem_i(pr_q),
    .quo_i(pq_q),
    .div_i(md_q),
    .rem_o(pr_n),
    .quo_o(pq_n)
  );
  always_comb begin
    sg = op_q == ALU_DIV;
    dvd_neg = sg & dvd_q[WIDTH-1];
    dvs_neg = sg & dvs_q[WIDTH-1];
    q_fix = (dvd_neg ^ dvs_neg) ? -pq_q : pq_q;
    r_fix = dvd_neg ? -pr_q : pr_q;
    state_d = state_q;
    cnt_d = cnt_q;
    op_d = op_q;
    dvd_d = dvd_q;
    dvs_d = dvs_q;
    pr_d = pr_q;
    pq_d = pq_q;
    md_d = md_q;
    quotient_d = quotient_q;
    remainder_d = remainder_q;
    zero_d = zero_q;
    sign_d = sign_q;
    ovf_d = ovf_q;
    dbz_d = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = start ? PREP : IDLE;
        if (start) begin
          op_d = is_signed ? ALU_DIV : ALU_DIVU;
          dvd_d = dividend;
          dvs_d = divisor;
        end
      end
      PREP: begin
        pq_d = dvd_neg ? -dvd_q : dvd_q;
        md_d = dvs_neg ? -dvs_q : dvs_q;
        pr_d = '0;
        cnt_d = '0;
        state_d = (dvs_q == '0) ? DONE : ITER;
        if (dvs_q == '0) begin
          quotient_d = '1;
          remainder_d = dvd_q;
          zero_d = 1'b0;
          sign_d = 1'b1;
          ovf_d = 1'b0;
          dbz_d = 1'b1;
        end
      end
      ITER: begin
        pr_d = pr_n;
        pq_d = pq_n;
        cnt_d = cnt_q + 6'd1;
        state_d = (cnt_q == 6'(ITER_COUNT - 1)) ? FIX : ITER;
      end
      FIX: begin
        quotient_d = q_fix;
        remainder_d = r_fix;
        zero_d = q_fix == '0;
        sign_d = q_fix[WIDTH-1];
        ovf_d = sg && dvd_q == {1'b1, {(WIDTH-1){1'b0}}} && dvs_q == '1;
        dbz_d = 1'b0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= '0;
      dvd_q <= '0;
      dvs_q <= '0;
      pr_q <= '0;
      pq_q <= '0;
      md_q <= '0;
      quotient_q <= '0;
      remainder_q <= '0;
      zero_q <= 1'b0;
      sign_q <= 1'b0;
      ovf_q <= 1'b0;
      dbz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
      pr_q <= pr_d;
      pq_q <= pq_d;
      md_q <= md_d;
      quotient_q <= quotient_d;
      remainder_q <= remainder_d;
      zero_q <= zero_d;
      sign_q <= sign_d;
      ovf_q <= ovf_d;
      dbz_q <= dbz_d;
    end
  end
  assign busy = state_q inside {PREP, ITER, FIX};
  assign done = state_q == DONE;
  assign quotient = quotient_q;
  assign remainder = remainder_q;
  assign zero_flag = zero_q;
  assign sign_flag = sign_q;
  assign overflow_flag = ovf_q;
  assign div_by_zero = dbz_q;
endmodule
